// File: rtl/decode_stage_pipe_pkg.sv
// decode_stage_pipe_pkg
//   Shared decode definitions for the buffered MIPS-I decode stage.
//   Holds field widths, the opcode constants the decoder keys on, the
//   instruction class codes, the per-entry field record, and two helpers:
//   opcode classification and the legal R-type function list.
package decode_stage_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM_W   = 16;
  localparam int JT_W    = 26;
  localparam int CLS_W   = 3;

  localparam logic [OPC_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OPC_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [OPC_W-1:0] OP_J      = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL    = 6'h03;
  localparam logic [OPC_W-1:0] OP_BR_LO  = 6'h04;
  localparam logic [OPC_W-1:0] OP_BR_HI  = 6'h07;
  localparam logic [OPC_W-1:0] OP_ALUI_LO = 6'h08;
  localparam logic [OPC_W-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI    = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI   = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI    = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LD_LO  = 6'h20;
  localparam logic [OPC_W-1:0] OP_LD_HI  = 6'h25;
  localparam logic [OPC_W-1:0] OP_ST_LO  = 6'h28;
  localparam logic [OPC_W-1:0] OP_ST_HI  = 6'h2B;

  typedef enum logic [CLS_W-1:0] {
    CLS_R      = 3'd0,
    CLS_ALUI   = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_OTHER  = 3'd7
  } cls_e;

  // One decoded entry minus the XLEN/PC_W-wide parts, which depend on
  // module parameters and are stored alongside.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [FUNC_W-1:0] func;
    logic [JT_W-1:0]   jt;
    cls_e              cls;
  } fields_t;

  function automatic cls_e classify(input logic [OPC_W-1:0] op);
    cls_e c;
    if (op == OP_RTYPE)                              c = CLS_R;
    else if (op >= OP_ALUI_LO && op <= OP_LUI)       c = CLS_ALUI;
    else if (op >= OP_LD_LO && op <= OP_LD_HI)       c = CLS_LOAD;
    else if (op >= OP_ST_LO && op <= OP_ST_HI)       c = CLS_STORE;
    else if (op == OP_REGIMM ||
             (op >= OP_BR_LO && op <= OP_BR_HI))     c = CLS_BRANCH;
    else if (op == OP_J || op == OP_JAL)             c = CLS_JUMP;
    else                                             c = CLS_OTHER;
    return c;
  endfunction

  // SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, ADD..NOR, SLT, SLTU.
  function automatic logic func_legal(input logic [FUNC_W-1:0] f);
    logic ok;
    case (f)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_fields.sv
// decode_stage_pipe_fields
//   Combinational instruction splitter used at the push side of the
//   decode buffer: field extraction, immediate extension to XLEN and
//   classification.
//   Ports:
//     instr    in   32    instruction word
//     fields   out        opcode/rs/rt/rd/shamt/func/jump target/class
//     imm_ext  out  XLEN  extended immediate
//     illegal  out  1     only with DECODE_ILLEGAL_EN: class OTHER, or
//                         R-type with an unrecognised function code
//   Macro: DECODE_ILLEGAL_EN
module decode_stage_pipe_fields
  import decode_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output fields_t            fields,
`ifdef DECODE_ILLEGAL_EN
  output logic               illegal,
`endif
  output logic [XLEN-1:0]    imm_ext
);

  function automatic logic [XLEN-1:0] zext16(input logic [IMM_W-1:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [IMM_W-1:0] v);
    logic signed [IMM_W-1:0] s;
    s = $signed(v);
    return XLEN'(s);
  endfunction

  // LUI places the immediate in the upper half of a 32-bit word; on wider
  // datapaths that word is sign-extended, so bit 15 of imm fills the top.
  function automatic logic [XLEN-1:0] lui_ext(input logic [IMM_W-1:0] v);
    logic signed [31:0] s;
    s = $signed({v, 16'h0000});
    return XLEN'(s);
  endfunction

  logic [IMM_W-1:0] imm;

  always_comb begin
    imm           = instr[15:0];
    fields.opcode = instr[31:26];
    fields.rs     = instr[25:21];
    fields.rt     = instr[20:16];
    fields.rd     = instr[15:11];
    fields.shamt  = instr[10:6];
    fields.func   = instr[5:0];
    fields.jt     = instr[25:0];
    fields.cls    = classify(instr[31:26]);

    case (instr[31:26])
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = zext16(imm);
      OP_LUI:                   imm_ext = lui_ext(imm);
      default:                  imm_ext = sext16(imm);
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  always_comb begin
    illegal = (fields.cls == CLS_OTHER) ||
              ((fields.cls == CLS_R) && !func_legal(instr[5:0]));
  end
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
//   Handshaked decode stage between fetch and issue. Each accepted
//   instruction is decoded immediately and the decoded record is queued in
//   a DEPTH-entry circular buffer; the head entry drives the out_* bus.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     flush             synchronous discard of every buffered entry
//     in_valid/in_ready fetch handshake; in_ready = buffer not full
//     in_instr, in_pc   instruction word and its address
//     out_valid/out_ready issue handshake on the head entry
//     out_opcode, out_rs, out_rt, out_rd, out_shamt, out_func,
//     out_imm_ext, out_jump_target, out_class, out_pc   head entry fields
//     out_illegal, illegal_seen   only with DECODE_ILLEGAL_EN
//   Macro: DECODE_ILLEGAL_EN adds illegal-instruction flagging and a
//   sticky "an illegal entry was consumed" indicator.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_shamt,
  output logic [FUNC_W-1:0]  out_func,
  output logic [XLEN-1:0]    out_imm_ext,
  output logic [JT_W-1:0]    out_jump_target,
  output logic [CLS_W-1:0]   out_class,
`ifdef DECODE_ILLEGAL_EN
  output logic               out_illegal,
  output logic               illegal_seen,
`endif
  output logic [PC_W-1:0]    out_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Stage 0: decode at the buffer input
  fields_t          fields_p0;
  logic [XLEN-1:0]  imm_p0;
`ifdef DECODE_ILLEGAL_EN
  logic             ill_p0;
`endif

  decode_stage_pipe_fields #(.XLEN(XLEN)) u_fields (
    .instr   (in_instr),
    .fields  (fields_p0),
`ifdef DECODE_ILLEGAL_EN
    .illegal (ill_p0),
`endif
    .imm_ext (imm_p0)
  );

  // Stage 1: buffer storage, head drives the outputs
  fields_t          ent_p1 [DEPTH];
  logic [XLEN-1:0]  imm_p1 [DEPTH];
  logic [PC_W-1:0]  pc_p1  [DEPTH];
`ifdef DECODE_ILLEGAL_EN
  logic             ill_p1 [DEPTH];
`endif

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // in_ready depends only on registered occupancy, so a full buffer
  // refuses a push even when the head is being popped in the same cycle.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_p1[i] <= '0;
        imm_p1[i] <= '0;
        pc_p1[i]  <= '0;
`ifdef DECODE_ILLEGAL_EN
        ill_p1[i] <= 1'b0;
`endif
      end
    end else if (flush) begin
      // Storage is left untouched so the output bus keeps its last value.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ent_p1[wr_ptr] <= fields_p0;
        imm_p1[wr_ptr] <= imm_p0;
        pc_p1[wr_ptr]  <= in_pc;
`ifdef DECODE_ILLEGAL_EN
        ill_p1[wr_ptr] <= ill_p0;
`endif
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen <= 1'b0;
    end else if (flush) begin
      illegal_seen <= 1'b0;
    end else if (pop && ill_p1[rd_ptr]) begin
      illegal_seen <= 1'b1;
    end
  end

  assign out_illegal = ill_p1[rd_ptr];
`endif

  assign out_opcode      = ent_p1[rd_ptr].opcode;
  assign out_rs          = ent_p1[rd_ptr].rs;
  assign out_rt          = ent_p1[rd_ptr].rt;
  assign out_rd          = ent_p1[rd_ptr].rd;
  assign out_shamt       = ent_p1[rd_ptr].shamt;
  assign out_func        = ent_p1[rd_ptr].func;
  assign out_jump_target = ent_p1[rd_ptr].jt;
  assign out_class       = ent_p1[rd_ptr].cls;
  assign out_imm_ext     = imm_p1[rd_ptr];
  assign out_pc          = pc_p1[rd_ptr];

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]      out_func;
  logic [XLEN-1:0] out_imm_ext;
  logic [25:0]     out_jump_target;
  logic [2:0]      out_class;
  logic [PC_W-1:0] out_pc;
`ifdef DECODE_ILLEGAL_EN
  logic            out_illegal;
  logic            illegal_seen;
`endif

  decode_stage_pipe #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_opcode      (out_opcode),
    .out_rs          (out_rs),
    .out_rt          (out_rt),
    .out_rd          (out_rd),
    .out_shamt       (out_shamt),
    .out_func        (out_func),
    .out_imm_ext     (out_imm_ext),
    .out_jump_target (out_jump_target),
    .out_class       (out_class),
`ifdef DECODE_ILLEGAL_EN
    .out_illegal     (out_illegal),
    .illegal_seen    (illegal_seen),
`endif
    .out_pc          (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [2:0]  cls;
    logic        ill;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int op, fn;
    logic [15:0] i16;
    bit fok;
    op    = int'(w >> 26);
    fn    = int'(w & 32'h3F);
    i16   = w[15:0];
    r.op  = w[31:26];
    r.rs  = w[25:21];
    r.rt  = w[20:16];
    r.rd  = w[15:11];
    r.sh  = w[10:6];
    r.fn  = w[5:0];
    r.jt  = w[25:0];
    if (op == 12 || op == 13 || op == 14) r.imm = {16'h0000, i16};
    else if (op == 15)                    r.imm = {i16, 16'h0000};
    else                                  r.imm = {{16{i16[15]}}, i16};
    if (op == 0)                         r.cls = 3'd0;
    else if (op >= 8 && op <= 15)        r.cls = 3'd1;
    else if (op >= 32 && op <= 37)       r.cls = 3'd2;
    else if (op >= 40 && op <= 43)       r.cls = 3'd3;
    else if (op == 1 || (op >= 4 && op <= 7)) r.cls = 3'd4;
    else if (op == 2 || op == 3)         r.cls = 3'd5;
    else                                 r.cls = 3'd7;
    fok = (fn == 0) || (fn == 2) || (fn == 3) || (fn == 4) || (fn == 6) || (fn == 7) ||
          (fn == 8) || (fn == 9) || (fn >= 32 && fn <= 39) || (fn == 42) || (fn == 43);
    r.ill = (r.cls == 3'd7) || (r.cls == 3'd0 && !fok);
    return r;
  endfunction

  function automatic logic [127:0] exp_pack(input ref_t r, input logic [31:0] pc);
`ifdef DECODE_ILLEGAL_EN
    return 128'({r.op, r.rs, r.rt, r.rd, r.sh, r.fn, r.imm, r.jt, r.cls, pc, r.ill});
`else
    return 128'({r.op, r.rs, r.rt, r.rd, r.sh, r.fn, r.imm, r.jt, r.cls, pc});
`endif
  endfunction

  function automatic logic [127:0] act_pack();
`ifdef DECODE_ILLEGAL_EN
    return 128'({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_func, out_imm_ext,
                 out_jump_target, out_class, out_pc, out_illegal});
`else
    return 128'({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_func, out_imm_ext,
                 out_jump_target, out_class, out_pc});
`endif
  endfunction

  // Scoreboard: queued words/PCs, log of consumed words, sticky model.
  logic [31:0] qi[$];
  logic [31:0] qp[$];
  logic [31:0] popped[$];
  bit          seen_m;

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check the present outputs against the model, then advance one clock.
  task automatic cyc();
    int   n;
    ref_t h;
    n = qi.size();
    chk("in_ready", 128'(in_ready), 128'(n != DEPTH));
    chk("out_valid", 128'(out_valid), 128'(n != 0));
    if (n != 0) begin
      h = ref_decode(qi[0]);
      chk("head", act_pack(), exp_pack(h, qp[0]));
    end
`ifdef DECODE_ILLEGAL_EN
    chk("illegal_seen", 128'(illegal_seen), 128'(seen_m));
`endif
    if (flush) begin
      qi.delete();
      qp.delete();
      seen_m = 1'b0;
    end else begin
      if (n != 0 && out_ready) begin
        h = ref_decode(qi[0]);
        if (h.ill) seen_m = 1'b1;
        popped.push_back(qi[0]);
        void'(qi.pop_front());
        void'(qp.pop_front());
      end
      if (in_valid && n != DEPTH) begin
        qi.push_back(in_instr);
        qp.push_back(in_pc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [2:0]  cls;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] wa, wb, wc;
    vt[0]  = '{32'h2008FFFC, 6'h08, 5'd8, 32'hFFFFFFFC, 26'h008FFFC, 3'd1};
    vt[1]  = '{32'h3508FFFF, 6'h0D, 5'd8, 32'h0000FFFF, 26'h108FFFF, 3'd1};
    vt[2]  = '{32'h3C081234, 6'h0F, 5'd8, 32'h12340000, 26'h0081234, 3'd1};
    vt[3]  = '{32'h3C088000, 6'h0F, 5'd8, 32'h80000000, 26'h0088000, 3'd1};
    vt[4]  = '{32'h08000010, 6'h02, 5'd0, 32'h00000010, 26'h0000010, 3'd5};
    vt[5]  = '{32'h8C820004, 6'h23, 5'd2, 32'h00000004, 26'h0820004, 3'd2};
    vt[6]  = '{32'hAC82FFF8, 6'h2B, 5'd2, 32'hFFFFFFF8, 26'h082FFF8, 3'd3};
    vt[7]  = '{32'h1085FFFE, 6'h04, 5'd5, 32'hFFFFFFFE, 26'h085FFFE, 3'd4};
    vt[8]  = '{32'h00851020, 6'h00, 5'd5, 32'h00001020, 26'h0851020, 3'd0};
    vt[9]  = '{32'h3883800F, 6'h0E, 5'd3, 32'h0000800F, 26'h083800F, 3'd1};
    vt[10] = '{32'h30A5F000, 6'h0C, 5'd5, 32'h0000F000, 26'h0A5F000, 3'd1};
    vt[11] = '{32'hFC000000, 6'h3F, 5'd0, 32'h00000000, 26'h0000000, 3'd7};

    seen_m = 1'b0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_data", act_pack(), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed decode table: push alone, check one cycle later, pop.
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, vt[k].instr, 32'h1000 + 32'(k * 4), 1'b0, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("vec_valid", 128'(out_valid), 128'(1));
      chk("vec_fields", 128'({out_opcode, out_rt, out_imm_ext, out_jump_target, out_class}),
          128'({vt[k].op, vt[k].rt, vt[k].imm, vt[k].jt, vt[k].cls}));
`ifdef DECODE_ILLEGAL_EN
      chk("vec_illegal", 128'(out_illegal), 128'(vt[k].cls == 3'd7));
`endif
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
`ifdef DECODE_ILLEGAL_EN
    chk("seen_sticky", 128'(illegal_seen), 128'(1));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("seen_cleared", 128'(illegal_seen), 128'(0));
`endif

    // Back-to-back pushes into a stalled buffer, then drain in order.
    wa = 32'h2001AAAA; wb = 32'h8C02BBBB; wc = 32'hAC03CCCC;
    popped.delete();
    drive(1'b1, wa, 32'h200, 1'b0, 1'b0); cyc();
    drive(1'b1, wb, 32'h204, 1'b0, 1'b0); cyc();
    chk("full_in_ready", 128'(in_ready), 128'(0));
    drive(1'b1, wc, 32'h208, 1'b0, 1'b0); cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 8 && qi.size() + popped.size() < 4; k++) begin
      if (qi.size() == 3 || (qi.size() + popped.size()) >= 3) in_valid = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6 && qi.size() != 0; k++) cyc();
    chk("drain_count", 128'(popped.size()), 128'(3));
    if (popped.size() == 3)
      chk("drain_order", 128'({popped[0], popped[1], popped[2]}), 128'({wa, wb, wc}));
    out_ready = 1'b0;

    // Flush a full buffer while a new word is offered.
    popped.delete();
    drive(1'b1, 32'h24010001, 32'h300, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h24020002, 32'h304, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h24030003, 32'h308, 1'b0, 1'b1); cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    drive(1'b1, 32'h24040004, 32'h30C, 1'b0, 1'b0); cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cyc();
    out_ready = 1'b0;
    chk("post_flush_words", 128'({popped.size(), popped.size() > 0 ? popped[0] : 32'h0}),
        128'({32'd1, 32'h24040004}));

    // Reset asserted mid-stream with two entries queued.
    drive(1'b1, 32'h2005FFFF, 32'h400, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h3C06ABCD, 32'h404, 1'b0, 1'b0); cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_data", act_pack(), 128'(0));
    qi.delete(); qp.delete(); seen_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 600; k++) begin
      logic [5:0]  op;
      logic [31:0] w;
      case ($urandom_range(0, 9))
        0: op = 6'h00;
        1: op = 6'h0F;
        2: op = 6'(8 + $urandom_range(0, 7));
        3: op = 6'(32 + $urandom_range(0, 5));
        4: op = 6'(40 + $urandom_range(0, 3));
        5: op = 6'($urandom_range(1, 7));
        default: op = 6'($urandom_range(0, 63));
      endcase
      w = {op, 26'($urandom)};
      drive(1'($urandom_range(0, 1)), w, $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
